// File: rtl/snake_pkg.sv
// snake_pkg: shared definitions for the snake game datapath and its controllers.
//   dir_e     one-hot move command (UP=1000, DOWN=0100, LEFT=0010, RIGHT=0001, 0000 = hold)
//   state_e   game state encoding (IDLE=00, PLAY=01, PAUSE=10, OVER=11)
//   step_t    signed per-axis displacement for one move
//   opposite  180-degree reverse of a direction
//   step      displacement of one move of cell_size pixels
package snake_pkg;

  localparam int unsigned DefaultHRes = 1280;
  localparam int unsigned DefaultVRes = 1024;

  typedef enum logic [3:0] {
    DirNone  = 4'b0000,
    DirUp    = 4'b1000,
    DirDown  = 4'b0100,
    DirLeft  = 4'b0010,
    DirRight = 4'b0001
  } dir_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StPlay  = 2'b01,
    StPause = 2'b10,
    StOver  = 2'b11
  } state_e;

  typedef struct packed {
    logic signed [11:0] dx;
    logic signed [11:0] dy;
  } step_t;

  function automatic dir_e opposite(input dir_e dir);
    case (dir)
      DirUp:    return DirDown;
      DirDown:  return DirUp;
      DirLeft:  return DirRight;
      DirRight: return DirLeft;
      default:  return DirNone;
    endcase
  endfunction

  // Screen coordinates: y grows downwards, so UP is a negative y step.
  function automatic step_t step(input dir_e dir, input logic [10:0] cell_size);
    logic signed [11:0] c;
    step_t              s;
    c = $signed({1'b0, cell_size});
    s = '0;
    case (dir)
      DirUp:    s.dy = -c;
      DirDown:  s.dy = c;
      DirLeft:  s.dx = -c;
      DirRight: s.dx = c;
      default:  ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/snake_head_tracker.sv
// snake_head_tracker: shadow copy of the datapath head position plus a one-move lookahead.
//   upd_clk, rst_n  game-tick clock, asynchronous active-low reset
//   reset_i         synchronous game reset (head returns to START on the next edge)
//   move_dir_i      command currently presented to the datapath
//   proj_dir_i      direction the controller intends to issue on this edge
//   cell_size_i     step size in pixels
//   head_x_o/_y_o   shadow head, equal to the datapath head at every edge
//   legal_o         the move in proj_dir_i after the pending move stays on the playfield
module snake_head_tracker
  import snake_pkg::*;
#(
  parameter int unsigned H_RES   = DefaultHRes,
  parameter int unsigned V_RES   = DefaultVRes,
  parameter int unsigned START_X = 50,
  parameter int unsigned START_Y = 500
) (
  input  logic        upd_clk,
  input  logic        rst_n,
  input  logic        reset_i,
  input  dir_e        move_dir_i,
  input  dir_e        proj_dir_i,
  input  logic [10:0] cell_size_i,
  output logic [10:0] head_x_o,
  output logic [10:0] head_y_o,
  output logic        legal_o
);

  logic [10:0]        head_x_q, head_y_q;
  logic [10:0]        head_x_d, head_y_d;
  logic signed [11:0] proj_x, proj_y;
  logic signed [11:0] lim_x, lim_y;
  step_t              mv_step, pj_step;

  always_comb begin
    mv_step = step(move_dir_i, cell_size_i);
    pj_step = step(proj_dir_i, cell_size_i);

    // head_next: where the datapath head lands on this edge.
    if (reset_i) begin
      head_x_d = 11'(START_X);
      head_y_d = 11'(START_Y);
    end else begin
      head_x_d = head_x_q + mv_step.dx[10:0];
      head_y_d = head_y_q + mv_step.dy[10:0];
    end

    // Projection one move further: the move the controller is about to command.
    proj_x = $signed({1'b0, head_x_d}) + pj_step.dx;
    proj_y = $signed({1'b0, head_y_d}) + pj_step.dy;
    lim_x  = $signed(12'(H_RES)) - $signed({1'b0, cell_size_i});
    lim_y  = $signed(12'(V_RES)) - $signed({1'b0, cell_size_i});

    legal_o = (proj_x >= 12'sd0) && (proj_x <= lim_x) &&
              (proj_y >= 12'sd0) && (proj_y <= lim_y);
  end

  always_ff @(posedge upd_clk or negedge rst_n) begin
    if (!rst_n) begin
      head_x_q <= 11'(START_X);
      head_y_q <= 11'(START_Y);
    end else begin
      head_x_q <= head_x_d;
      head_y_q <= head_y_d;
    end
  end

  assign head_x_o = head_x_q;
  assign head_y_o = head_y_q;

endmodule

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: game-tick controller feeding the snake position datapath.
//   upd_clk, rst_n          game-tick clock, asynchronous active-low reset
//   btn_up/down/left/right  debounced direction button levels
//   btn_start               debounced start/pause level (edge-detected here)
//   food_eaten              single-tick pulse from the food block
//   cell_size               step size in pixels, static outside IDLE
//   move_dir                one-hot move command to the datapath (0000 = hold)
//   reset                   synchronous game reset to the datapath
//   length                  snake length in cells
//   head_x, head_y          shadow head position
//   game_over               high in OVER
//   state                   IDLE=00, PLAY=01, PAUSE=10, OVER=11
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned H_RES    = DefaultHRes,
  parameter int unsigned V_RES    = DefaultVRes,
  parameter int unsigned START_X  = 50,
  parameter int unsigned START_Y  = 500,
  parameter int unsigned INIT_LEN = 3,
  parameter int unsigned MAX_LEN  = 32
) (
  input  logic        upd_clk,
  input  logic        rst_n,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_start,
  input  logic        food_eaten,
  input  logic [10:0] cell_size,
  output logic [3:0]  move_dir,
  output logic        reset,
  output logic [7:0]  length,
  output logic [10:0] head_x,
  output logic [10:0] head_y,
  output logic        game_over,
  output logic [1:0]  state
);

  state_e     state_q;
  dir_e       move_dir_q, heading_q;
  logic       reset_q, game_over_q, start_q;
  logic [7:0] length_q;

  logic       start_pulse;
  dir_e       req_dir, new_dir, proj_dir;
  logic       proj_legal;
  logic [7:0] length_inc;

  assign start_pulse = btn_start & ~start_q;

  always_comb begin
    req_dir = DirNone;
    if (btn_up) begin
      req_dir = DirUp;
    end else if (btn_down) begin
      req_dir = DirDown;
    end else if (btn_left) begin
      req_dir = DirLeft;
    end else if (btn_right) begin
      req_dir = DirRight;
    end

    if ((req_dir == DirNone) || (req_dir == opposite(heading_q))) begin
      new_dir = heading_q;
    end else begin
      new_dir = req_dir;
    end

    // A resume from PAUSE re-issues the stored heading, so that is what gets checked.
    proj_dir = (state_q == StPause) ? heading_q : new_dir;

    length_inc = (length_q < 8'(MAX_LEN)) ? length_q + 8'd1 : length_q;
  end

  snake_head_tracker #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .START_X(START_X),
    .START_Y(START_Y)
  ) u_head_tracker (
    .upd_clk    (upd_clk),
    .rst_n      (rst_n),
    .reset_i    (reset_q),
    .move_dir_i (move_dir_q),
    .proj_dir_i (proj_dir),
    .cell_size_i(cell_size),
    .head_x_o   (head_x),
    .head_y_o   (head_y),
    .legal_o    (proj_legal)
  );

  always_ff @(posedge upd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      move_dir_q  <= DirNone;
      heading_q   <= DirRight;
      reset_q     <= 1'b1;
      length_q    <= 8'(INIT_LEN);
      game_over_q <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      start_q <= btn_start;
      unique case (state_q)
        StIdle: begin
          move_dir_q  <= DirNone;
          heading_q   <= DirRight;
          reset_q     <= 1'b1;
          length_q    <= 8'(INIT_LEN);
          game_over_q <= 1'b0;
          if (start_pulse) begin
            state_q    <= StPlay;
            reset_q    <= 1'b0;
            move_dir_q <= DirRight;
          end
        end
        StPlay: begin
          // Pause beats collision; the collision is re-checked on resume.
          if (start_pulse) begin
            state_q    <= StPause;
            move_dir_q <= DirNone;
          end else if (!proj_legal) begin
            state_q     <= StOver;
            move_dir_q  <= DirNone;
            game_over_q <= 1'b1;
          end else begin
            heading_q  <= new_dir;
            move_dir_q <= new_dir;
            if (food_eaten) begin
              length_q <= length_inc;
            end
          end
        end
        StPause: begin
          move_dir_q <= DirNone;
          if (start_pulse) begin
            if (!proj_legal) begin
              state_q     <= StOver;
              game_over_q <= 1'b1;
            end else begin
              state_q    <= StPlay;
              move_dir_q <= heading_q;
            end
          end
        end
        StOver: begin
          move_dir_q <= DirNone;
          if (start_pulse) begin
            state_q     <= StIdle;
            game_over_q <= 1'b0;
            reset_q     <= 1'b1;
            heading_q   <= DirRight;
            length_q    <= 8'(INIT_LEN);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign move_dir  = move_dir_q;
  assign reset     = reset_q;
  assign length    = length_q;
  assign game_over = game_over_q;
  assign state     = state_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Bench for snake_dir_ctrl: directed phases followed by random play, each tick checked
// against a behavioural model of the game rules kept in plain integers.
module tb_snake_dir_ctrl;

  localparam int HR = 1280;
  localparam int VR = 1024;
  localparam int SX = 50;
  localparam int SY = 500;
  localparam int IL = 3;
  localparam int ML = 32;

  logic        upd_clk = 1'b0;
  logic        rst_n;
  logic        btn_up, btn_down, btn_left, btn_right, btn_start, food_eaten;
  logic [10:0] cell_size;
  logic [3:0]  move_dir;
  logic        reset;
  logic [7:0]  length;
  logic [10:0] head_x, head_y;
  logic        game_over;
  logic [1:0]  state;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: state 0 idle, 1 play, 2 pause, 3 over; directions 0 up, 1 down, 2 left,
  // 3 right, -1 hold (so d^1 is the reverse direction).
  int m_state, m_head, m_move, m_len, m_hx, m_hy;
  bit m_reset, m_go, m_startq;

  snake_dir_ctrl #(
    .H_RES   (HR),
    .V_RES   (VR),
    .START_X (SX),
    .START_Y (SY),
    .INIT_LEN(IL),
    .MAX_LEN (ML)
  ) dut (
    .upd_clk   (upd_clk),
    .rst_n     (rst_n),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_start (btn_start),
    .food_eaten(food_eaten),
    .cell_size (cell_size),
    .move_dir  (move_dir),
    .reset     (reset),
    .length    (length),
    .head_x    (head_x),
    .head_y    (head_y),
    .game_over (game_over),
    .state     (state)
  );

  always #5 upd_clk = ~upd_clk;

  function automatic int onehot(input int d);
    return (d < 0) ? 0 : (8 >> d);
  endfunction

  function automatic int dx_of(input int d, input int cs);
    return (d == 2) ? -cs : (d == 3) ? cs : 0;
  endfunction

  function automatic int dy_of(input int d, input int cs);
    return (d == 0) ? -cs : (d == 1) ? cs : 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_head = 3; m_move = -1; m_len = IL;
    m_hx = SX; m_hy = SY; m_reset = 1; m_go = 0; m_startq = 0;
  endtask

  task automatic model_step();
    int  cs, hxn, hyn, req, nd, pd, px, py;
    bit  sp, legal;
    cs  = int'(cell_size);
    sp  = btn_start && !m_startq;
    hxn = m_reset ? SX : m_hx + dx_of(m_move, cs);
    hyn = m_reset ? SY : m_hy + dy_of(m_move, cs);
    req = btn_up ? 0 : btn_down ? 1 : btn_left ? 2 : btn_right ? 3 : -1;
    nd  = (req < 0 || req == (m_head ^ 1)) ? m_head : req;
    pd  = (m_state == 2) ? m_head : nd;
    px  = hxn + dx_of(pd, cs);
    py  = hyn + dy_of(pd, cs);
    legal = (px >= 0) && (px <= HR - cs) && (py >= 0) && (py <= VR - cs);
    case (m_state)
      0: begin
        if (sp) begin m_state = 1; m_reset = 0; m_move = 3; end
      end
      1: begin
        if (sp) begin
          m_state = 2; m_move = -1;
        end else if (!legal) begin
          m_state = 3; m_move = -1; m_go = 1;
        end else begin
          m_head = nd; m_move = nd;
          if (food_eaten && m_len < ML) m_len = m_len + 1;
        end
      end
      2: begin
        if (sp) begin
          if (!legal) begin m_state = 3; m_go = 1; end
          else begin m_state = 1; m_move = m_head; end
        end
      end
      default: begin
        if (sp) begin
          m_state = 0; m_go = 0; m_reset = 1; m_head = 3; m_len = IL;
        end
      end
    endcase
    m_hx = hxn;
    m_hy = hyn;
    m_startq = btn_start;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("move_dir", 32'(move_dir), onehot(m_move));
    check("state", 32'(state), m_state);
    check("reset", 32'(reset), 32'(m_reset));
    check("length", 32'(length), m_len);
    check("head_x", 32'(head_x), m_hx);
    check("head_y", 32'(head_y), m_hy);
    check("game_over", 32'(game_over), 32'(m_go));
  endtask

  // One game tick: model follows the edge, outputs are sampled 1 ns later,
  // and control returns at the falling edge for the next input update.
  task automatic tick();
    @(posedge upd_clk);
    model_step();
    #1;
    check_all();
    @(negedge upd_clk);
  endtask

  task automatic release_buttons();
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_start = 0; food_eaten = 0;
  endtask

  initial begin
    int len_before;
    int start_hold;
    int sizes [5];
    sizes = '{8, 10, 16, 20, 32};

    release_buttons();
    cell_size = 11'd20;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge upd_clk);
    check_all();
    rst_n = 1'b1;
    repeat (2) tick();

    // Start and run right.
    btn_start = 1; tick();
    check("start_dir", 32'(move_dir), 32'h1);
    check("start_reset", 32'(reset), 0);
    btn_start = 0;
    tick(); check("run_x1", 32'(head_x), 70);
    tick(); check("run_x2", 32'(head_x), 90);

    // Reversal is rejected; UP wins over LEFT.
    btn_left = 1; tick(); check("reverse", 32'(move_dir), 32'h1);
    btn_up = 1;   tick(); check("prio_up", 32'(move_dir), 32'h8);
    release_buttons();
    btn_right = 1; tick(); check("turn_right", 32'(move_dir), 32'h1);
    release_buttons();

    // Run into the right wall; food offered on the collision edge is dropped.
    len_before = m_len;
    for (int i = 0; i < 100 && game_over !== 1'b1; i++) begin
      food_eaten = (m_hx + 2 * 20 > HR - 20) ? 1'b1 : 1'b0;
      len_before = m_len;
      tick();
    end
    food_eaten = 0;
    check("wall_over", 32'(game_over), 1);
    check("wall_hold", 32'(move_dir), 0);
    check("wall_len", 32'(length), len_before);
    check("wall_inside", 32'(head_x <= 11'(HR - 20)), 1);
    tick();

    // OVER -> IDLE, holding start gives one transition only.
    btn_start = 1; tick();
    check("idle_state", 32'(state), 0);
    check("idle_reset", 32'(reset), 1);
    check("idle_len", 32'(length), IL);
    tick();
    check("idle_hold", 32'(state), 0);
    check("idle_hx", 32'(head_x), SX);
    check("idle_hy", 32'(head_y), SY);
    btn_start = 0; tick();

    // Food counting and saturation.
    cell_size = 11'd10;
    btn_start = 1; tick(); btn_start = 0;
    for (int i = 0; i < 80; i++) begin
      food_eaten = (i % 2 == 0);
      tick();
      if (i == 9) check("food_5", 32'(length), 8);
    end
    food_eaten = 0;
    check("food_sat", 32'(length), ML);

    // Pause and resume.
    btn_up = 1; tick(); release_buttons(); tick();
    btn_start = 1; tick();
    check("pause_state", 32'(state), 2);
    check("pause_dir", 32'(move_dir), 0);
    tick(); check("pause_held", 32'(state), 2);
    btn_start = 0;
    btn_left = 1; repeat (3) tick(); btn_left = 0;
    btn_start = 1; tick();
    check("resume_state", 32'(state), 1);
    check("resume_dir", 32'(move_dir), 32'h8);
    btn_start = 0; repeat (3) tick();

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge upd_clk);
    @(negedge upd_clk);
    rst_n = 1'b1;
    repeat (3) tick();
    check("rst_idle", 32'(state), 0);
    btn_start = 1; tick(); btn_start = 0;
    check("rst_restart", 32'(state), 1);

    // Random play.
    start_hold = 0;
    for (int i = 0; i < 1500; i++) begin
      btn_up    = ($urandom_range(0, 5) == 0);
      btn_down  = ($urandom_range(0, 5) == 0);
      btn_left  = ($urandom_range(0, 5) == 0);
      btn_right = ($urandom_range(0, 5) == 0);
      food_eaten = ($urandom_range(0, 7) == 0);
      if (start_hold > 0) begin
        start_hold--;
      end else if ($urandom_range(0, 29) == 0) begin
        start_hold = $urandom_range(1, 3);
      end
      btn_start = (start_hold > 0);
      if (m_state == 0 && $urandom_range(0, 3) == 0) begin
        cell_size = 11'(sizes[$urandom_range(0, 4)]);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
